// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: divider ALU op codes, divider FSM states and the iteration count.
package mips32_pkg;

  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left one place and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder can reach 2*divisor-1, so the trial needs one extra bit.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial = {rem, quo[WIDTH-1]};
  assign diff  = trial - {1'b0, divisor};

  always_comb begin
    rem_next = trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      rem_next    = diff[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/exe_div_unit.sv
// Multi-cycle restoring DIV/DIVU unit for the execute stage; LO gets the quotient, HI the remainder.
// Define DIV_SIGNED_EN to honour signed_i and build the sign-magnitude conversion and fix-up.
module exe_div_unit
  import mips32_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             stall_req_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             accept, last, dvs_zero;

  assign accept   = (state_q == IDLE) && start_i && !cancel_i;
  assign last     = (count_q == CW'(WIDTH - 1));
  assign dvs_zero = (divisor_i == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

`ifdef DIV_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic neg_quo_q, neg_rem_q;

  assign dvd_neg = signed_i && dividend_i[WIDTH-1];
  assign dvs_neg = signed_i && divisor_i[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i : divisor_i;
  assign quo_fix = neg_quo_q ? -quo_nx : quo_nx;
  assign rem_fix = neg_rem_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept && !dvs_zero) begin
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign dvd_mag       = dividend_i;
  assign dvs_mag       = divisor_i;
  assign quo_fix       = quo_nx;
  assign rem_fix       = rem_nx;
`endif

  // A flush from any state wins over every other transition.
  always_comb begin
    state_d     = state_q;
    stall_req_o = accept || (state_q == RUN);
    ready_o     = (state_q == DONE);
    if (cancel_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = dvs_zero ? DONE : RUN;
        RUN:     if (last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !dvs_zero) begin
        rem_q   <= '0;
        quo_q   <= dvd_mag;
        dvs_q   <= dvs_mag;
        count_q <= '0;
      end else if (accept) begin
        quotient_o    <= '1;
        remainder_o   <= dividend_i;
        div_by_zero_o <= 1'b1;
      end else if (state_q == RUN && !cancel_i) begin
        rem_q   <= rem_nx;
        quo_q   <= quo_nx;
        count_q <= count_q + 1'b1;
        if (last) begin
          quotient_o    <= quo_fix;
          remainder_o   <= rem_fix;
          div_by_zero_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: directed DIV/DIVU vectors, stall/ready timing, cancel and reset.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, signed_i, cancel_i;
  logic [31:0] dividend_i, divisor_i;
  logic        stall_req_o, ready_o, div_by_zero_o;
  logic [31:0] quotient_o, remainder_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  exe_div_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .cancel_i      (cancel_i),
    .stall_req_o   (stall_req_o),
    .ready_o       (ready_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issues one operation at cycle T, checks stall through T+lat-1 and the ready pulse at T+lat.
  task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                               input logic edz);
    exp_t e;
    int   lat;
    lat   = (b == 32'd0) ? 1 : 33;
    e.name = name; e.q = eq; e.r = er; e.dbz = edz;
    sb.push_back(e);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      checkOutput({name, "_stall"}, {31'd0, stall_req_o}, 32'd1);
      checkOutput({name, "_early_ready"}, {31'd0, ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput({name, "_done_stall"}, {31'd0, stall_req_o}, 32'd0);
    checkOutput({name, "_ready"}, {31'd0, ready_o}, 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput({name, "_ready_pulse"}, {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every ready pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: got ready 1, expected no result at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_quotient"}, quotient_o, e.q);
          checkOutput({e.name, "_remainder"}, remainder_o, e.r);
          checkOutput({e.name, "_dbz"}, {31'd0, div_by_zero_o}, {31'd0, e.dbz});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_quotient", quotient_o, 32'd0);
    checkOutput("rst_remainder", remainder_o, 32'd0);
    checkOutput("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
`ifdef DIV_SIGNED_EN
    applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
`else
    applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    applyStimulus("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0);
`endif
    applyStimulus("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    applyStimulus("divu_3_5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd3, 1'b0);
    applyStimulus("divu_by_zero", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

    // Same-cycle cancel and start: nothing starts.
    start_i = 1'b1; cancel_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
    @(negedge clk);
    checkOutput("cancel_start_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;

    // Cancel at T+10: back to IDLE, no ready, previous result held.
    start_i = 1'b1; dividend_i = 32'd1000; divisor_i = 32'd10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("cancel_run_stall", {31'd0, stall_req_o}, 32'd1);
      @(posedge clk); #1;
    end
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0; start_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checkOutput("cancel_idle_stall", {31'd0, stall_req_o}, 32'd0);
      checkOutput("cancel_no_ready", {31'd0, ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("cancel_hold_quotient", quotient_o, 32'hFFFF_FFFF);
    checkOutput("cancel_hold_remainder", remainder_o, 32'h0000_1234);
    checkOutput("cancel_hold_dbz", {31'd0, div_by_zero_o}, 32'd1);

    applyStimulus("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Reset at T+5 of an operation: outputs clear at once and the unit stays idle.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    checkOutput("midrst_quotient", quotient_o, 32'd0);
    checkOutput("midrst_remainder", remainder_o, 32'd0);
    checkOutput("midrst_dbz", {31'd0, div_by_zero_o}, 32'd0);
    checkOutput("midrst_stall", {31'd0, stall_req_o}, 32'd0);
    checkOutput("midrst_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checkOutput("postrst_stall", {31'd0, stall_req_o}, 32'd0);
      checkOutput("postrst_ready", {31'd0, ready_o}, 32'd0);
      @(posedge clk); #1;
    end

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_div_unit.md
# exe_div_unit

Multi-cycle integer divider in the execute stage for DIV/DIVU. It consumes the operands and operation class presented by the decode/execute pipeline register and holds the front of the pipeline through a stall request while it iterates. It returns quotient and remainder for the HI/LO write path: LO gets the quotient, HI gets the remainder. It uses a restoring algorithm that produces one quotient bit per cycle.

## Interface
- WIDTH, 32, operand width; DIV_CYCLES = WIDTH iterations
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start_i  input  1  EXE instruction is DIV/DIVU (decoded from exe_aluop)
- signed_i  input  1  1 = DIV, 0 = DIVU
- dividend_i  input  WIDTH  exe_src1
- divisor_i  input  WIDTH  exe_src2
- cancel_i  input  1  pipeline flush; abort the current operation
- stall_req_o  output  1  hold PC, IF/ID and ID/EXE registers
- ready_o  output  1  result valid, single-cycle pulse
- quotient_o  output  WIDTH  quotient, registered
- remainder_o  output  WIDTH  remainder, registered
- div_by_zero_o  output  1  last completed operation had divisor 0

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - Enter RUN when start_i=1 and cancel_i=0 and divisor_i≠0.
  - Enter DONE when start_i=1 and cancel_i=0 and divisor_i=0.
  - On RUN entry, latch |dividend| and |divisor| (magnitudes when signed, raw when unsigned), the sign flags, clear the partial remainder and set counter=0.
- **RUN**
  - Each cycle: shift {rem, quo} left by 1, bringing in the dividend MSB.
  - If rem ≥ divisor: rem -= divisor and set quotient LSB to 1.
  - counter increments each cycle. Leave for DONE when counter=WIDTH-1.
- **DONE**
  - ready_o=1 for exactly one cycle, then return to IDLE unconditionally. start_i is ignored in DONE.
- **Sign fix (applied on DONE entry)**
  - Negate the quotient when signs differ.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- **Divide by zero**
  - quotient_o=all-ones, remainder_o=dividend_i, div_by_zero_o=1.
  - Otherwise div_by_zero_o=0 on completion.
- stall_req_o = (IDLE & start_i & ~cancel_i) | RUN. It is combinational and 0 in DONE, so the pipeline advances on the DONE edge.
- **Cancel:** cancel_i=1 in any state moves to IDLE on the next edge. No ready_o pulse. quotient_o, remainder_o and div_by_zero_o keep their previous values.
- quotient_o, remainder_o and div_by_zero_o update only on DONE entry and hold until the next completion.

## Timing
- Reset values: state IDLE, counter 0, ready_o 0, stall_req_o 0 (given start_i=0), quotient_o 0, remainder_o 0, div_by_zero_o 0. Internal operand registers are 0.
- Normal operation, with the start accepted at cycle T:
  - stall_req_o is high in cycles T through T+WIDTH.
  - DONE and ready_o occur in cycle T+WIDTH+1, which is T+33 for WIDTH=32.
- Divisor 0: stall_req_o is high in cycle T only; DONE in T+1.
- start_i stays high during the stall because ID/EXE is held. It is not re-sampled until IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.
- If cancel_i and start_i arrive in the same IDLE cycle, cancel_i wins: no start, and stall_req_o=0.

## Configuration
- DIV_SIGNED_EN defined: signed_i is honoured and the sign-magnitude conversion and fix-up logic is built.
- DIV_SIGNED_EN undefined: signed_i is ignored, all operations are unsigned, and no negation logic is built. The port list is unchanged.

## Structure
- Shared package mips32_pkg holds:
  - ALUOP_DIV and ALUOP_DIVU codes, which the decoder uses to form start_i and signed_i
  - the state typedef {IDLE, RUN, DONE}
  - DIV_CYCLES
- Sub-module div_step: one combinational restoring iteration, taking (rem, quo, divisor) and producing (rem', quo'). It is instantiated once and driven by the RUN registers.

## Test plan
- DIVU 100 / 7, start at T: stall_req_o high T..T+32; ready_o at T+33; quotient 14, remainder 2, div_by_zero_o 0.
- DIV 0xFFFFFFF9 (-7) / 2 with DIV_SIGNED_EN: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Without DIV_SIGNED_EN: quotient 0x7FFFFFFC, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 at T+33.
- DIVU 0x1234 / 0: stall high only at T; ready_o at T+1; quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero_o 1.
- Cancel at T+10: IDLE at T+11; stall low; no ready_o; outputs keep the previous result. A new DIVU 9/3 then completes with 3/0.
- rst_n low at T+5: all outputs return to 0 immediately. After release with start_i=0, the unit stays IDLE and stall_req_o=0.
